// File: rtl/masked_match_counter.sv
// Streaming masked-pattern detector with a saturating hit counter and a
// one-beat config reload handshake.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RUN    | normal streaming; config and input words both accepted
//   UPDATE | single cycle after a config accept; both handshakes stalled
module masked_match_counter #(
    parameter int                 WIDTH         = 8,
    parameter int                 CNT_WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_PATTERN = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   RESET_MASK    = {WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_pattern,
    input  logic [WIDTH-1:0]      cfg_mask,
    input  logic                  cfg_invert,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  clear,
    output logic                  match_valid,
    output logic                  match,
    output logic                  any_bit,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic                  count_sat
);

    typedef enum logic {
        RUN    = 1'b0,
        UPDATE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  pattern_q;
    logic [WIDTH-1:0]  mask_q;
    logic              invert_q;

    logic              cfg_accept;
    logic              word_accept;
    logic [WIDTH-1:0]  x;
    logic              hit;
    logic              any;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake readies; both readies are forced low during reset.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    cfg_ready = 1'b1;
                    in_ready  = 1'b1;
                    if (cfg_valid) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Compare datapath, always against the currently active config.
    always_comb begin
        cfg_accept  = cfg_valid & cfg_ready;
        word_accept = in_valid & in_ready;
        x           = in_data ^ {WIDTH{invert_q}};
        hit         = ~|((x ^ pattern_q) & mask_q);
        any         = |(x & mask_q);
    end

    // Config registers; a word accepted alongside the beat still sees the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= RESET_PATTERN;
            mask_q    <= RESET_MASK;
            invert_q  <= 1'b0;
        end else if (cfg_accept) begin
            pattern_q <= cfg_pattern;
            mask_q    <= cfg_mask;
            invert_q  <= cfg_invert;
        end
    end

    // Registered per-word result; match/any_bit hold when no word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_valid <= 1'b0;
            match       <= 1'b0;
            any_bit     <= 1'b0;
        end else begin
            match_valid <= word_accept;
            if (word_accept) begin
                match   <= hit;
                any_bit <= any;
            end
        end
    end

    // Saturating hit counter; clear and config accept win over a same-edge hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (clear || cfg_accept) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (word_accept && hit && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
            if (match_count == CNT_MAX - 1'b1) begin
                count_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_masked_match_counter.sv
// Directed bench for masked_match_counter: a default-width instance and a
// 4-bit-counter instance share the same stimulus.
module tb_masked_match_counter;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [7:0]  cfg_pattern;
    logic [7:0]  cfg_mask;
    logic        cfg_invert;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clear;

    logic        cfg_ready,   cfg_ready4;
    logic        in_ready,    in_ready4;
    logic        match_valid, match_valid4;
    logic        match,       match4;
    logic        any_bit,     any_bit4;
    logic [15:0] match_count;
    logic [3:0]  match_count4;
    logic        count_sat,   count_sat4;

    int n_cmp = 0;
    int n_err = 0;

    masked_match_counter dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_invert(cfg_invert),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .clear(clear),
        .match_valid(match_valid), .match(match), .any_bit(any_bit),
        .match_count(match_count), .count_sat(count_sat)
    );

    masked_match_counter #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_invert(cfg_invert),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .clear(clear),
        .match_valid(match_valid4), .match(match4), .any_bit(any_bit4),
        .match_count(match_count4), .count_sat(count_sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic mv, input logic m, input logic a,
                           input logic [15:0] cnt);
        chk({tag, "_mv"},    {31'd0, match_valid}, {31'd0, mv});
        chk({tag, "_match"}, {31'd0, match},       {31'd0, m});
        chk({tag, "_any"},   {31'd0, any_bit},     {31'd0, a});
        chk({tag, "_cnt"},   {16'd0, match_count}, {16'd0, cnt});
        chk({tag, "_cnt4"},  {28'd0, match_count4}, {28'd0, cnt[3:0]});
        chk({tag, "_m4"},    {31'd0, match4},      {31'd0, m});
    endtask

    task automatic send_cfg(input logic [7:0] p, input logic [7:0] m, input logic inv);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_invert  = inv;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = 8'h00; cfg_mask = 8'h00;
        cfg_invert = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
        cyc();
        cyc();
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk_res("rst", 1'b0, 1'b0, 1'b0, 16'd0);
        chk("rst_sat", {31'd0, count_sat}, 32'd0);
        rst = 1'b0;
        #1;
        chk("run_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("run_in_ready",  {31'd0, in_ready},  32'd1);

        // 1: reset config, pattern 00 mask FF
        in_valid = 1'b1; in_data = 8'h00;
        cyc();
        chk_res("t1a", 1'b1, 1'b1, 1'b0, 16'd1);
        in_data = 8'h01;
        cyc();
        chk_res("t1b", 1'b1, 1'b0, 1'b1, 16'd1);
        in_valid = 1'b0;
        cyc();
        chk_res("t1_idle", 1'b0, 1'b0, 1'b1, 16'd1);

        // 2: pattern 17 mask F0
        send_cfg(8'b0001_0111, 8'hF0, 1'b0);
        chk("t2_upd_in_ready",  {31'd0, in_ready},  32'd0);
        chk("t2_upd_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("t2_upd_cnt", {16'd0, match_count}, 32'd0);
        cyc();
        chk("t2_run_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 8'h1C;
        cyc();
        chk_res("t2a", 1'b1, 1'b1, 1'b1, 16'd1);
        in_data = 8'h2C;
        cyc();
        chk_res("t2b", 1'b1, 1'b0, 1'b1, 16'd1);
        in_valid = 1'b0;

        // 3: pattern 0F mask FF inverted
        send_cfg(8'h0F, 8'hFF, 1'b1);
        cyc();
        in_valid = 1'b1; in_data = 8'hF0;
        cyc();
        chk_res("t3a", 1'b1, 1'b1, 1'b1, 16'd1);
        in_data = 8'h0F;
        cyc();
        chk_res("t3b", 1'b1, 1'b0, 1'b1, 16'd1);
        in_valid = 1'b0;

        // 4: all-zero mask, 20 hits, saturation of the 4-bit counter
        send_cfg(8'h00, 8'h00, 1'b0);
        cyc();
        in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_data = 8'(i * 37);
            cyc();
            if (i == 14) begin
                chk("t4_14_cnt4", {28'd0, match_count4}, 32'hE);
                chk("t4_14_sat4", {31'd0, count_sat4}, 32'd0);
            end
            if (i == 15) begin
                chk("t4_15_cnt4", {28'd0, match_count4}, 32'hF);
                chk("t4_15_sat4", {31'd0, count_sat4}, 32'd1);
            end
        end
        chk("t4_20_cnt4", {28'd0, match_count4}, 32'hF);
        chk("t4_20_sat4", {31'd0, count_sat4}, 32'd1);
        chk("t4_20_cnt",  {16'd0, match_count}, 32'd20);
        chk("t4_20_sat",  {31'd0, count_sat}, 32'd0);
        chk("t4_20_any",  {31'd0, any_bit}, 32'd0);
        chk("t4_20_match", {31'd0, match}, 32'd1);
        clear = 1'b1; in_data = 8'h5A;
        cyc();
        clear = 1'b0;
        chk_res("t4_clr", 1'b1, 1'b1, 1'b0, 16'd0);
        chk("t4_clr_sat4", {31'd0, count_sat4}, 32'd0);

        // 5: config beat and word in the same cycle
        in_data = 8'h00;
        cyc();
        chk("t5_pre_cnt", {16'd0, match_count}, 32'd1);
        cfg_valid = 1'b1; cfg_pattern = 8'hFF; cfg_mask = 8'hFF; cfg_invert = 1'b0;
        in_data = 8'h00;
        cyc();
        cfg_valid = 1'b0; in_valid = 1'b0;
        chk_res("t5_same", 1'b1, 1'b1, 1'b0, 16'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        in_valid = 1'b1; in_data = 8'h00;
        cyc();
        chk_res("t5_new", 1'b1, 1'b0, 1'b0, 16'd0);

        // 6: rst right after a word is accepted
        in_data = 8'hFF;
        cyc();
        chk_res("t6_pre", 1'b1, 1'b1, 1'b1, 16'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("t6_rst_in_ready",  {31'd0, in_ready},  32'd0);
        cyc();
        chk_res("t6_rst", 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        #1;
        chk("t6_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t6_in_ready",  {31'd0, in_ready},  32'd1);
        in_data = 8'h00;
        cyc();
        chk_res("t6_a", 1'b1, 1'b1, 1'b0, 16'd1);
        in_data = 8'h01;
        cyc();
        chk_res("t6_b", 1'b1, 1'b0, 1'b1, 16'd1);
        in_valid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
